// File: rtl/maze_level_engine.sv
// Maze level renderer and game engine: path rectangles, start/finish zones, a movable player
// sprite, per-pixel collision detection and an IDLE/PLAY/WIN/LOSE FSM. Optional macro: MAZE_LIVES_EN.
module maze_level_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_SEGS    = 4,
    parameter logic [10*NUM_SEGS-1:0] SEG_X = {10'd400, 10'd280, 10'd160, 10'd0},
    parameter logic [10*NUM_SEGS-1:0] SEG_Y = {10'd220, 10'd190, 10'd140, 10'd90},
    parameter logic [10*NUM_SEGS-1:0] SEG_W = {10'd220, 10'd120, 10'd120, 10'd160},
    parameter logic [10*NUM_SEGS-1:0] SEG_H = {10'd35, 10'd100, 10'd200, 10'd300},
    parameter logic [39:0] START_RECT  = {10'd0, 10'd90, 10'd50, 10'd300},
    parameter logic [39:0] FINISH_RECT = {10'd600, 10'd220, 10'd50, 10'd35},
    parameter int START_X     = 10,
    parameter int START_Y     = 200,
    parameter int PLAYER_SIZE = 16,
    parameter int STEP        = 4,
    parameter int MOVE_DIV    = 2
`ifdef MAZE_LIVES_EN
    , parameter int LIVES     = 3
`endif
) (
    input  logic       pixel_clk,
    input  logic       resetSwitch,
    input  logic [9:0] col,
    input  logic [8:0] row,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [1:0] game_state
`ifdef MAZE_LIVES_EN
    , output logic [3:0] lives_left
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;

    localparam logic [10:0] H11   = 11'(H_ACTIVE);
    localparam logic [10:0] V11   = 11'(V_ACTIVE);
    localparam logic [10:0] PS11  = 11'(PLAYER_SIZE);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - PLAYER_SIZE);
    localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - PLAYER_SIZE);
    localparam logic [9:0]  SPAWN_X = 10'(START_X);
    localparam logic [9:0]  SPAWN_Y = 10'(START_Y);
    localparam logic [7:0]  DIV_LAST = 8'(MOVE_DIV - 1);

    // 11-bit compares so x+w never wraps; bounds are half-open.
    function automatic logic in_rect(input logic [10:0] cx, cy, x, y, w, h);
        return (cx >= x) && (cx < x + w) && (cy >= y) && (cy < y + h);
    endfunction

    state_t      state, state_nx;
    logic [9:0]  px, py, px_nx, py_nx;
    logic [7:0]  frame_cnt, cnt_nx;
    logic        hit_flag, fin_flag;
    logic [11:0] rgb_nx;
`ifdef MAZE_LIVES_EN
    logic [3:0]  lives_nx;
`endif

    logic [10:0] cx, cy;
    logic        active, fe, in_player, in_start, in_fin, seg_any;
    logic        hit_pix, fin_pix, hit_now, fin_now;
    logic [NUM_SEGS-1:0] seg_in;

    assign cx = {1'b0, col};
    assign cy = {2'b0, row};
    assign active = (cx < H11) && (cy < V11);
    assign fe = (cx == H11 - 11'd1) && (cy == V11 - 11'd1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEGS; gi++) begin : g_seg
            assign seg_in[gi] = in_rect(cx, cy, {1'b0, SEG_X[10*gi +: 10]}, {1'b0, SEG_Y[10*gi +: 10]},
                                        {1'b0, SEG_W[10*gi +: 10]}, {1'b0, SEG_H[10*gi +: 10]});
        end
    endgenerate

    assign seg_any   = |seg_in;
    assign in_player = in_rect(cx, cy, {1'b0, px}, {1'b0, py}, PS11, PS11);
    assign in_start  = in_rect(cx, cy, {1'b0, START_RECT[39:30]}, {1'b0, START_RECT[29:20]},
                               {1'b0, START_RECT[19:10]}, {1'b0, START_RECT[9:0]});
    assign in_fin    = in_rect(cx, cy, {1'b0, FINISH_RECT[39:30]}, {1'b0, FINISH_RECT[29:20]},
                               {1'b0, FINISH_RECT[19:10]}, {1'b0, FINISH_RECT[9:0]});

    assign hit_pix = (state == PLAY) && active && in_player && !seg_any && !in_start && !in_fin;
    assign fin_pix = (state == PLAY) && active && in_player && in_fin;
    // Include the frame-end pixel itself in the decision taken on that cycle.
    assign hit_now = hit_flag | hit_pix;
    assign fin_now = fin_flag | fin_pix;
    assign game_state = state;

    always_comb begin
        rgb_nx = 12'h000;
        if (active) begin
            if (in_player)           rgb_nx = 12'h00F;
            else if (in_start)       rgb_nx = 12'h0F0;
            else if (in_fin)         rgb_nx = 12'hF00;
            else if (seg_any)        rgb_nx = 12'hFFF;
            else if (state == LOSE)  rgb_nx = 12'h400;
            else if (state == WIN)   rgb_nx = 12'h040;
        end
    end

    always_comb begin
        state_nx = state;
        px_nx    = px;
        py_nx    = py;
        cnt_nx   = frame_cnt;
`ifdef MAZE_LIVES_EN
        lives_nx = lives_left;
`endif
        if (fe) begin
            cnt_nx = 8'd0;
            if (state == PLAY) begin
                if (frame_cnt == DIV_LAST) begin
                    if (btn_up && !btn_down)
                        py_nx = (py < STEP10) ? 10'd0 : py - STEP10;
                    else if (btn_down && !btn_up)
                        py_nx = (py > Y_MAX - STEP10) ? Y_MAX : py + STEP10;
                    if (btn_left && !btn_right)
                        px_nx = (px < STEP10) ? 10'd0 : px - STEP10;
                    else if (btn_right && !btn_left)
                        px_nx = (px > X_MAX - STEP10) ? X_MAX : px + STEP10;
                end else begin
                    cnt_nx = frame_cnt + 8'd1;
                end
            end
            case (state)
                IDLE: if (btn_start) state_nx = PLAY;
                PLAY: begin
                    if (hit_now) begin
`ifdef MAZE_LIVES_EN
                        if (lives_left <= 4'd1) begin
                            lives_nx = 4'd0;
                            state_nx = LOSE;
                        end else begin
                            lives_nx = lives_left - 4'd1;
                            px_nx    = SPAWN_X;
                            py_nx    = SPAWN_Y;
                        end
`else
                        state_nx = LOSE;
`endif
                    end else if (fin_now) begin
                        state_nx = WIN;
                    end
                end
                default: if (btn_start) begin
                    state_nx = IDLE;
                    px_nx    = SPAWN_X;
                    py_nx    = SPAWN_Y;
`ifdef MAZE_LIVES_EN
                    lives_nx = 4'(LIVES);
`endif
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge resetSwitch) begin
        if (resetSwitch) begin
            {red, green, blue} <= 12'h000;
            state     <= IDLE;
            px        <= SPAWN_X;
            py        <= SPAWN_Y;
            frame_cnt <= 8'd0;
            hit_flag  <= 1'b0;
            fin_flag  <= 1'b0;
`ifdef MAZE_LIVES_EN
            lives_left <= 4'(LIVES);
`endif
        end else begin
            {red, green, blue} <= rgb_nx;
            state     <= state_nx;
            px        <= px_nx;
            py        <= py_nx;
            frame_cnt <= cnt_nx;
            if (fe) begin
                hit_flag <= 1'b0;
                fin_flag <= 1'b0;
            end else begin
                hit_flag <= hit_now;
                fin_flag <= fin_now;
            end
`ifdef MAZE_LIVES_EN
            lives_left <= lives_nx;
`endif
        end
    end
endmodule
